multi_tone_gen: RTL and testbench

Parametrised, time-multiplexed multi-channel tone synthesiser; the successor to the single fixed square-wave generator. Each of NUM_CH channels owns a phase accumulator, frequency control word and waveform mode. On every `next_sample` request from the PWM DAC, the block walks the channels one per cycle, mixes them and presents a new `code` to the DAC. Channel settings are written through a simple write port driven by the button/switch control logic.

---
 rtl/multi_tone_gen.sv | 149 ++++++++++++++
 tb/tb_multi_tone_gen.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_tone_gen.sv
// multi_tone_gen: time-multiplexed NUM_CH-channel tone mixer feeding the PWM DAC.
// Optional per-channel attenuation is built when MULTI_TONE_GEN_VOLUME_EN is defined.
module multi_tone_gen #(
  parameter int NUM_CH  = 4,
  parameter int CODE_W  = 10,
  parameter int PHASE_W = 24,
  localparam int LOG_CH = $clog2(NUM_CH),
  localparam int CH_W   = (LOG_CH < 1) ? 1 : LOG_CH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               next_sample,
  input  logic               cfg_we,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [PHASE_W-1:0] cfg_fcw,
  input  logic [1:0]         cfg_mode,
  input  logic               cfg_en,
  input  logic               cfg_phase_rst,
  input  logic [1:0]         cfg_vol,
  output logic [CODE_W-1:0]  code,
  output logic               busy,
  output logic               overrun
);

  localparam int ACC_W = CODE_W + LOG_CH;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_e;

  state_e             state_q;
  logic [CH_W-1:0]    idx_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CODE_W-1:0]  code_q;
  logic               busy_q;
  logic               ovr_q;

  logic [PHASE_W-1:0] phase_q [NUM_CH];
  logic [PHASE_W-1:0] fcw_q   [NUM_CH];
  logic [1:0]         mode_q  [NUM_CH];
  logic [NUM_CH-1:0]  en_q;

  logic [CODE_W:0]    p_hi;
  logic [CODE_W-1:0]  tri_t;
  logic [CODE_W-1:0]  samp_d;
  logic               wr;
  logic               step;

  assign wr   = cfg_we && (int'(cfg_ch) < NUM_CH);
  assign step = (state_q == ACCUM);

`ifdef MULTI_TONE_GEN_VOLUME_EN
  logic [1:0] vol_q [NUM_CH];
`else
  logic unused_vol;
  assign unused_vol = ^cfg_vol;
`endif

  // MSB plus the CODE_W bits below it cover saw, triangle and square
  always_comb begin
    p_hi   = phase_q[idx_q][PHASE_W-1 -: CODE_W+1];
    tri_t  = p_hi[CODE_W-1:0];
    samp_d = '0;
    if (en_q[idx_q]) begin
      unique case (mode_q[idx_q])
        2'b00:   samp_d = {CODE_W{p_hi[CODE_W]}};
        2'b01:   samp_d = p_hi[CODE_W:1];
        2'b10:   samp_d = p_hi[CODE_W] ? ~tri_t : tri_t;
        default: samp_d = '0;
      endcase
    end
`ifdef MULTI_TONE_GEN_VOLUME_EN
    samp_d = samp_d >> vol_q[idx_q];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      code_q  <= '0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (next_sample && state_q != IDLE)
        ovr_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (next_sample) begin
            acc_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          acc_q <= acc_q + ACC_W'(samp_d);
          idx_q <= idx_q + 1'b1;
          if (idx_q == CH_W'(NUM_CH - 1))
            state_q <= DONE;
        end
        DONE: begin
          code_q  <= CODE_W'(acc_q >> LOG_CH);
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Config write is ordered after the step so it wins a same-cycle clash
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        phase_q[i] <= '0;
        fcw_q[i]   <= '0;
        mode_q[i]  <= '0;
`ifdef MULTI_TONE_GEN_VOLUME_EN
        vol_q[i]   <= '0;
`endif
      end
      en_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (step && idx_q == CH_W'(i) && en_q[i])
          phase_q[i] <= phase_q[i] + fcw_q[i];
        if (wr && cfg_ch == CH_W'(i)) begin
          fcw_q[i]  <= cfg_fcw;
          mode_q[i] <= cfg_mode;
          en_q[i]   <= cfg_en;
`ifdef MULTI_TONE_GEN_VOLUME_EN
          vol_q[i]  <= cfg_vol;
`endif
          if (cfg_phase_rst)
            phase_q[i] <= '0;
        end
      end
    end
  end

  assign code    = code_q;
  assign busy    = busy_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_multi_tone_gen.sv
// tb_multi_tone_gen: directed vector table plus hand sequences for
// latency, overrun and mid-sequence reset of multi_tone_gen.
module tb_multi_tone_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        next_sample = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [23:0] cfg_fcw = '0;
  logic [1:0]  cfg_mode = '0;
  logic        cfg_en = 1'b0;
  logic        cfg_phase_rst = 1'b0;
  logic [1:0]  cfg_vol = '0;
  logic [9:0]  code;
  logic        busy;
  logic        overrun;

  always #5 clk = ~clk;

  multi_tone_gen #(
    .NUM_CH (4),
    .CODE_W (10),
    .PHASE_W(24)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .next_sample  (next_sample),
    .cfg_we       (cfg_we),
    .cfg_ch       (cfg_ch),
    .cfg_fcw      (cfg_fcw),
    .cfg_mode     (cfg_mode),
    .cfg_en       (cfg_en),
    .cfg_phase_rst(cfg_phase_rst),
    .cfg_vol      (cfg_vol),
    .code         (code),
    .busy         (busy),
    .overrun      (overrun)
  );

  typedef struct {
    bit          we;
    logic [1:0]  ch;
    logic [23:0] fcw;
    logic [1:0]  mode;
    bit          en;
    bit          prst;
    logic [1:0]  vol;
    bit          req;
    int          exp;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  function automatic void add(bit we, int ch, int fcw, int mode,
                              bit en, bit prst, int vol,
                              bit req, int exp);
    vec_t v;
    v.we   = we;
    v.ch   = 2'(ch);
    v.fcw  = 24'(fcw);
    v.mode = 2'(mode);
    v.en   = en;
    v.prst = prst;
    v.vol  = 2'(vol);
    v.req  = req;
    v.exp  = exp;
    vecs.push_back(v);
  endfunction

  task automatic check(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_cfg(logic [1:0] ch, logic [23:0] fcw,
                        logic [1:0] mode, bit en, bit prst,
                        logic [1:0] vol);
    cfg_ch        = ch;
    cfg_fcw       = fcw;
    cfg_mode      = mode;
    cfg_en        = en;
    cfg_phase_rst = prst;
    cfg_vol       = vol;
    cfg_we        = 1'b1;
    @(posedge clk);
    #1;
    cfg_we        = 1'b0;
    cfg_phase_rst = 1'b0;
    cfg_vol       = '0;
  endtask

  task automatic wait_idle(string nm);
    bit ok;
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      if (!busy) begin
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check(nm, int'(ok), 1);
  endtask

  task automatic do_req(string nm, output int c);
    next_sample = 1'b1;
    @(posedge clk);
    #1;
    next_sample = 1'b0;
    wait_idle(nm);
    c = int'(code);
  endtask

  int tri_e[9] = '{0, 64, 128, 192, 255, 191, 127, 63, 0};
  int c;
  int nbusy;

  initial begin
    // disabled channels
    add(0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0);
    // square on ch0, period 16 requests
    add(1, 0, 1 << 20, 0, 1, 1, 0, 1, 0);
    for (int k = 2; k <= 17; k++)
      add(0, 0, 0, 0, 0, 0, 0, 1, (k >= 9 && k <= 16) ? 255 : 0);
    add(1, 0, 0, 0, 0, 1, 0, 1, 0);
    // saw on ch1
    add(1, 1, 1 << 14, 1, 1, 1, 0, 1, 0);
    for (int n = 1; n < 12; n++)
      add(0, 0, 0, 0, 0, 0, 0, 1, n >> 2);
    add(1, 1, 0, 0, 0, 1, 0, 0, 0);
    // triangle on ch2 across phase wrap
    add(1, 2, 1 << 21, 2, 1, 1, 0, 1, tri_e[0]);
    for (int n = 1; n < 9; n++)
      add(0, 0, 0, 0, 0, 0, 0, 1, tri_e[n]);
    add(1, 2, 0, 0, 0, 1, 0, 0, 0);
    // two squares mixed
    add(1, 0, 1 << 23, 0, 1, 1, 0, 0, 0);
    add(1, 3, 1 << 23, 0, 1, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 511);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 3, 0, 0, 0, 1, 0, 0, 0);
    // vol=2 square
    add(1, 0, 1 << 23, 0, 1, 1, 2, 1, 0);
`ifdef MULTI_TONE_GEN_VOLUME_EN
    add(0, 0, 0, 0, 0, 0, 0, 1, 63);
`else
    add(0, 0, 0, 0, 0, 0, 0, 1, 255);
`endif
    add(1, 0, 0, 0, 0, 1, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_code", int'(code), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ovr", int'(overrun), 0);

    foreach (vecs[i]) begin
      if (vecs[i].we)
        do_cfg(vecs[i].ch, vecs[i].fcw, vecs[i].mode,
               vecs[i].en, vecs[i].prst, vecs[i].vol);
      if (vecs[i].req) begin
        do_req($sformatf("vec%0d_done", i), c);
        check($sformatf("vec%0d", i), c, vecs[i].exp);
      end
    end

    // latency: saw n=4 gives code 1 at E+5
    do_cfg(2'd1, 24'(1 << 14), 2'd1, 1'b1, 1'b1, 2'd0);
    for (int n = 0; n < 4; n++) begin
      do_req("lat_pre_done", c);
      check("lat_pre", c, 0);
    end
    next_sample = 1'b1;
    @(posedge clk);
    #1;
    next_sample = 1'b0;
    for (int j = 0; j < 5; j++) begin
      check($sformatf("lat_busy%0d", j), int'(busy), 1);
      check($sformatf("lat_code%0d", j), int'(code), 0);
      @(posedge clk);
      #1;
    end
    check("lat_busy_fall", int'(busy), 0);
    check("lat_code_new", int'(code), 1);
    do_cfg(2'd1, 24'd0, 2'd0, 1'b0, 1'b1, 2'd0);

    // overrun: second pulse two cycles later
    check("ovr_pre", int'(overrun), 0);
    next_sample = 1'b1;
    @(posedge clk);
    #1;
    next_sample = 1'b0;
    @(posedge clk);
    #1;
    next_sample = 1'b1;
    @(posedge clk);
    #1;
    next_sample = 1'b0;
    check("ovr_set", int'(overrun), 1);
    wait_idle("ovr_done");
    nbusy = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (busy) nbusy++;
    end
    check("ovr_single", nbusy, 0);
    check("ovr_sticky", int'(overrun), 1);

    // reset mid-sequence
    do_cfg(2'd0, 24'(1 << 23), 2'd0, 1'b1, 1'b1, 2'd0);
    do_req("mid_a_done", c);
    check("mid_a", c, 0);
    do_req("mid_b_done", c);
    check("mid_b", c, 255);
    next_sample = 1'b1;
    @(posedge clk);
    #1;
    next_sample = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_busy", int'(busy), 0);
    check("mid_code", int'(code), 0);
    check("mid_ovr", int'(overrun), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_req("post_a_done", c);
    check("post_cfg_clr", c, 0);
    do_req("post_b_done", c);
    check("spacing_ok", int'(overrun), 0);

    // request landing on the DONE edge
    next_sample = 1'b1;
    @(posedge clk);
    #1;
    next_sample = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("done_pre_ovr", int'(overrun), 0);
    next_sample = 1'b1;
    @(posedge clk);
    #1;
    next_sample = 1'b0;
    check("done_busy", int'(busy), 0);
    check("done_ovr", int'(overrun), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
